fir_mac_scheduler: RTL and testbench



---
 rtl/fir_mac_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_scheduler.sv
// Sequencer for a shared FIR multiply-accumulate datapath: circular delay line,
// MAC issue, drain, capture and output handshake. Define FIR_SAT_EN for output saturation.
module fir_mac_scheduler #(
    parameter int NTAPS   = 40,
    parameter int DATA_W  = 32,
    parameter int ACC_W   = 40,
    parameter int MAC_LAT = 1,
    parameter int SHIFT   = 15,
    parameter int OUT_W   = 20
) (
    input  logic              Clock,
    input  logic              Rst,
    input  logic [DATA_W-1:0] InData,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Flush,
    output logic              MacEn,
    output logic              MacFirst,
    output logic [DATA_W-1:0] MacSample,
    output logic [5:0]        CoeffAddr,
    input  logic [ACC_W-1:0]  MacResult,
    output logic [OUT_W-1:0]  OutData,
    output logic              OutValid,
    input  logic              OutReady,
    output logic              Busy,
    output logic              SatFlag
);

    localparam int PTR_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int DRN_W = $clog2(MAC_LAT + 2);
    localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NTAPS - 1);
    localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(MAC_LAT);

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [DATA_W-1:0]  delay_line_r [NTAPS];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   tap_cnt_r;
    logic [DRN_W-1:0]   drain_cnt_r;

    logic [PTR_W-1:0]   wr_ptr_nxt_s;
    logic [PTR_W-1:0]   rd_ptr_nxt_s;
    logic [PTR_W-1:0]   tap_cnt_nxt_s;
    logic [DRN_W-1:0]   drain_cnt_nxt_s;
    logic               mac_en_nxt_s;
    logic               mac_first_nxt_s;
    logic [DATA_W-1:0]  mac_sample_nxt_s;
    logic [5:0]         coeff_addr_nxt_s;
    logic [OUT_W-1:0]   out_data_nxt_s;
    logic               out_valid_nxt_s;
    logic               sat_flag_nxt_s;

    logic               accept_s;
    logic               last_tap_s;
    logic               drain_done_s;
    logic               capture_s;
    logic [OUT_W-1:0]   window_s;
    logic               unused_acc_bits_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
        return (p == {PTR_W{1'b0}}) ? LAST_IDX : p - PTR_W'(1);
    endfunction

`ifdef FIR_SAT_EN
    // The result fits only when every bit from the window sign upward agrees.
    function automatic logic sat_needed(input logic [ACC_W-1:0] acc);
        logic [ACC_W-SHIFT-OUT_W:0] hi;
        hi = acc[ACC_W-1:SHIFT+OUT_W-1];
        return (hi != {(ACC_W-SHIFT-OUT_W+1){1'b0}}) && (hi != {(ACC_W-SHIFT-OUT_W+1){1'b1}});
    endfunction

    function automatic logic [OUT_W-1:0] sat_value(input logic negative);
        logic [OUT_W-1:0] v;
        if (negative) begin
            v = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            v = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    assign accept_s          = (state_r == ST_IDLE) && InValid && InReady;
    assign last_tap_s        = (tap_cnt_r == LAST_IDX);
    assign drain_done_s      = (drain_cnt_r == DRAIN_LAST);
    assign capture_s         = (state_r == ST_DRAIN) && drain_done_s;
    assign window_s          = MacResult[SHIFT+OUT_W-1:SHIFT];
    assign unused_acc_bits_s = ^{MacResult[ACC_W-1:SHIFT+OUT_W], MacResult[SHIFT-1:0]};

    // State register
    always_ff @(posedge Clock) begin
        if (Rst) begin
            state_r <= ST_CLEAR;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; a Flush coinciding with an accept is dropped
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (wr_ptr_r == LAST_IDX) state_nxt_s = ST_IDLE;
                else                      state_nxt_s = ST_CLEAR;
            end
            ST_IDLE: begin
                if (accept_s)   state_nxt_s = ST_ISSUE;
                else if (Flush) state_nxt_s = ST_CLEAR;
                else            state_nxt_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (last_tap_s) state_nxt_s = ST_DRAIN;
                else            state_nxt_s = ST_ISSUE;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_nxt_s = ST_OUT;
                else              state_nxt_s = ST_DRAIN;
            end
            ST_OUT: begin
                if (OutReady) state_nxt_s = ST_IDLE;
                else          state_nxt_s = ST_OUT;
            end
            default: state_nxt_s = ST_CLEAR;
        endcase
    end

    // Next values of pointers, counters and registered outputs
    always_comb begin
        wr_ptr_nxt_s    = wr_ptr_r;
        rd_ptr_nxt_s    = rd_ptr_r;
        tap_cnt_nxt_s   = {PTR_W{1'b0}};
        drain_cnt_nxt_s = {DRN_W{1'b0}};
        case (state_r)
            ST_CLEAR: begin
                wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
            end
            ST_IDLE: begin
                // Flush restarts the pointer so CLEAR always ends at entry 0.
                if (accept_s) begin
                    wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
                    rd_ptr_nxt_s = wr_ptr_r;
                end else if (Flush) begin
                    wr_ptr_nxt_s = {PTR_W{1'b0}};
                end else begin
                    wr_ptr_nxt_s = wr_ptr_r;
                end
            end
            ST_ISSUE: begin
                rd_ptr_nxt_s  = ptr_dec(rd_ptr_r);
                tap_cnt_nxt_s = last_tap_s ? {PTR_W{1'b0}} : tap_cnt_r + PTR_W'(1);
            end
            ST_DRAIN: begin
                drain_cnt_nxt_s = drain_done_s ? {DRN_W{1'b0}} : drain_cnt_r + DRN_W'(1);
            end
            ST_OUT: begin
                wr_ptr_nxt_s = wr_ptr_r;
            end
            default: begin
                wr_ptr_nxt_s = {PTR_W{1'b0}};
            end
        endcase

        if (state_r == ST_ISSUE) begin
            mac_en_nxt_s     = 1'b1;
            mac_first_nxt_s  = (tap_cnt_r == {PTR_W{1'b0}});
            mac_sample_nxt_s = delay_line_r[rd_ptr_r];
            coeff_addr_nxt_s = 6'(tap_cnt_r);
        end else begin
            mac_en_nxt_s     = 1'b0;
            mac_first_nxt_s  = 1'b0;
            mac_sample_nxt_s = {DATA_W{1'b0}};
            coeff_addr_nxt_s = 6'd0;
        end

        out_data_nxt_s  = OutData;
        out_valid_nxt_s = OutValid;
        sat_flag_nxt_s  = SatFlag;
        if (capture_s) begin
            out_valid_nxt_s = 1'b1;
`ifdef FIR_SAT_EN
            if (sat_needed(MacResult)) begin
                out_data_nxt_s = sat_value(MacResult[ACC_W-1]);
                sat_flag_nxt_s = 1'b1;
            end else begin
                out_data_nxt_s = window_s;
                sat_flag_nxt_s = SatFlag;
            end
`else
            out_data_nxt_s = window_s;
`endif
        end else if ((state_r == ST_OUT) && OutReady) begin
            out_valid_nxt_s = 1'b0;
        end else begin
            out_valid_nxt_s = OutValid;
        end
`ifndef FIR_SAT_EN
        sat_flag_nxt_s = 1'b0;
`endif
    end

    // Pointer, counter and output registers
    always_ff @(posedge Clock) begin
        if (Rst) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            tap_cnt_r   <= {PTR_W{1'b0}};
            drain_cnt_r <= {DRN_W{1'b0}};
            InReady     <= 1'b0;
            Busy        <= 1'b1;
            MacEn       <= 1'b0;
            MacFirst    <= 1'b0;
            MacSample   <= {DATA_W{1'b0}};
            CoeffAddr   <= 6'd0;
            OutData     <= {OUT_W{1'b0}};
            OutValid    <= 1'b0;
            SatFlag     <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_ptr_nxt_s;
            rd_ptr_r    <= rd_ptr_nxt_s;
            tap_cnt_r   <= tap_cnt_nxt_s;
            drain_cnt_r <= drain_cnt_nxt_s;
            InReady     <= (state_nxt_s == ST_IDLE);
            Busy        <= (state_nxt_s != ST_IDLE);
            MacEn       <= mac_en_nxt_s;
            MacFirst    <= mac_first_nxt_s;
            MacSample   <= mac_sample_nxt_s;
            CoeffAddr   <= coeff_addr_nxt_s;
            OutData     <= out_data_nxt_s;
            OutValid    <= out_valid_nxt_s;
            SatFlag     <= sat_flag_nxt_s;
        end
    end

    // Delay line storage; CLEAR zeroes every entry, so the array has no reset
    always_ff @(posedge Clock) begin
        if (!Rst && (state_r == ST_CLEAR)) begin
            delay_line_r[wr_ptr_r] <= {DATA_W{1'b0}};
        end else if (!Rst && accept_s) begin
            delay_line_r[wr_ptr_r] <= InData;
        end
    end

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed, table-driven bench for fir_mac_scheduler with a behavioural MAC unit
// using coefficients c[k] = 2k+3 and a one-cycle accumulator register.
module tb_fir_mac_scheduler;

    localparam int NTAPS  = 40;
    localparam int DATA_W = 32;
    localparam int ACC_W  = 40;
    localparam int OUT_W  = 20;
    localparam int SHIFT  = 15;

    logic              Clock = 1'b0;
    logic              Rst = 1'b1;
    logic [DATA_W-1:0] InData = '0;
    logic              InValid = 1'b0;
    logic              InReady;
    logic              Flush = 1'b0;
    logic              MacEn;
    logic              MacFirst;
    logic [DATA_W-1:0] MacSample;
    logic [5:0]        CoeffAddr;
    logic [ACC_W-1:0]  MacResult;
    logic [OUT_W-1:0]  OutData;
    logic              OutValid;
    logic              OutReady = 1'b1;
    logic              Busy;
    logic              SatFlag;

    always #5 Clock = ~Clock;

    fir_mac_scheduler dut (
        .Clock(Clock), .Rst(Rst), .InData(InData), .InValid(InValid), .InReady(InReady),
        .Flush(Flush), .MacEn(MacEn), .MacFirst(MacFirst), .MacSample(MacSample),
        .CoeffAddr(CoeffAddr), .MacResult(MacResult), .OutData(OutData), .OutValid(OutValid),
        .OutReady(OutReady), .Busy(Busy), .SatFlag(SatFlag)
    );

    // Behavioural MAC: result valid one cycle after each MacEn
    logic signed [ACC_W-1:0] acc_m = '0;
    logic                    force_sat = 1'b0;
    int                      n_accept = 0;

    function automatic longint prod(input logic [DATA_W-1:0] s, input logic [5:0] a);
        return longint'($signed(s)) * longint'(2 * int'(a) + 3);
    endfunction

    always @(posedge Clock) begin
        if (MacEn) begin
            if (MacFirst) acc_m <= ACC_W'(prod(MacSample, CoeffAddr));
            else          acc_m <= acc_m + ACC_W'(prod(MacSample, CoeffAddr));
        end
        if (InValid && InReady) n_accept <= n_accept + 1;
    end

    assign MacResult = force_sat ? 40'sh08_0000_0000 : acc_m;

    int n_cmp = 0;
    int n_err = 0;
    logic signed [31:0] exp_samples [NTAPS];

    typedef struct {
        logic signed [31:0] din;
        int                 exp_out;
    } vec_t;
    vec_t vecs [7];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (InReady !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (InReady !== 1'b1) chk("in_ready_timeout", InReady, 1);
    endtask

    task automatic wait_valid();
        int n = 0;
        while (OutValid !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        if (OutValid !== 1'b1) chk("out_valid_timeout", OutValid, 1);
    endtask

    task automatic accept(input logic signed [31:0] d);
        wait_ready();
        InData  = d;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
    endtask

    task automatic check_issue();
        for (int k = 0; k < NTAPS; k++) begin
            step();
            chk("issue_mac_en", MacEn, 1);
            chk("issue_coeff_addr", CoeffAddr, k);
            chk("issue_mac_first", MacFirst, (k == 0));
            chk("issue_mac_sample", $signed(MacSample), exp_samples[k]);
        end
    endtask

    task automatic check_clear();
        for (int i = 1; i <= NTAPS; i++) begin
            step();
            chk("clear_in_ready", InReady, (i == NTAPS));
            chk("clear_busy", Busy, (i != NTAPS));
            chk("clear_mac_en", MacEn, 0);
            chk("clear_out_valid", OutValid, 0);
        end
    endtask

    task automatic do_flush();
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        chk("flush_in_ready", InReady, 0);
        chk("flush_busy", Busy, 1);
        check_clear();
    endtask

    task automatic run_impulse();
        OutReady = 1'b1;
        for (int k = 0; k < NTAPS; k++) exp_samples[k] = (k == 0) ? 32'sd32768 : 32'sd0;
        accept(32'sd32768);
        check_issue();
        step();
        chk("impulse_drain_valid", OutValid, 0);
        chk("impulse_drain_mac_en", MacEn, 0);
        step();
        chk("impulse_out_valid", OutValid, 1);
        chk("impulse_out_data", $signed(OutData), 3);
        step();
        chk("impulse_release_valid", OutValid, 0);
        chk("impulse_in_ready", InReady, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, want completion");
        $fatal(1);
    end

    initial begin
        int exp_bp;
        int acc0;
        int n;
        logic exp_sat_flag;
        int exp_sat_out;

        vecs[0] = '{32'sd32768,    3};
        vecs[1] = '{32'sd65536,    11};
        vecs[2] = '{-32'sd32768,   14};
        vecs[3] = '{32'sd0,        18};
        vecs[4] = '{32'sd1,        22};
        vecs[5] = '{-32'sd2,       25};
        vecs[6] = '{-32'sd1310720, -91};
`ifdef FIR_SAT_EN
        exp_sat_out  = 524287;
        exp_sat_flag = 1'b1;
`else
        exp_sat_out  = 0;
        exp_sat_flag = 1'b0;
`endif

        // Reset values
        repeat (3) @(posedge Clock);
        #1;
        chk("rst_in_ready", InReady, 0);
        chk("rst_mac_en", MacEn, 0);
        chk("rst_mac_first", MacFirst, 0);
        chk("rst_mac_sample", MacSample, 0);
        chk("rst_coeff_addr", CoeffAddr, 0);
        chk("rst_out_data", OutData, 0);
        chk("rst_out_valid", OutValid, 0);
        chk("rst_sat_flag", SatFlag, 0);
        chk("rst_busy", Busy, 1);
        Rst = 1'b0;
        check_clear();

        run_impulse();

        // Convolution vectors on a freshly cleared line
        do_flush();
        for (int v = 0; v < 7; v++) begin
            accept(vecs[v].din);
            wait_valid();
            chk("vec_out_data", $signed(OutData), vecs[v].exp_out);
            step();
        end

        // Pointer wrap: sample 45 sits at index 4 and sees 45 down to 6
        do_flush();
        for (int s = 1; s <= 44; s++) begin
            accept(s);
            wait_valid();
            step();
        end
        for (int k = 0; k < NTAPS; k++) exp_samples[k] = 45 - k;
        accept(32'sd45);
        check_issue();
        wait_valid();
        step();

        // Backpressure with a pending input and an ignored Flush
        OutReady = 1'b0;
        accept(32'sd100);
        wait_valid();
        exp_bp = $signed(acc_m[SHIFT+OUT_W-1:SHIFT]);
        acc0 = n_accept;
        InData  = 32'd7;
        InValid = 1'b1;
        Flush   = 1'b1;
        repeat (10) begin
            step();
            chk("bp_out_valid", OutValid, 1);
            chk("bp_out_data", $signed(OutData), exp_bp);
            chk("bp_in_ready", InReady, 0);
        end
        Flush    = 1'b0;
        OutReady = 1'b1;
        step();
        chk("bp_release_valid", OutValid, 0);
        chk("bp_ready_after_handshake", InReady, 1);
        chk("bp_no_early_accept", n_accept, acc0);
        step();
        InValid = 1'b0;
        chk("bp_single_accept", n_accept, acc0 + 1);
        chk("bp_ready_low", InReady, 0);
        step();
        chk("bp_first_sample", $signed(MacSample), 7);
        chk("bp_first_flag", MacFirst, 1);
        wait_valid();
        step();

        // Saturation
        force_sat = 1'b1;
        accept(32'sd5);
        wait_valid();
        chk("sat_out_data", $signed(OutData), exp_sat_out);
        chk("sat_flag", SatFlag, exp_sat_flag);
        step();
        force_sat = 1'b0;

        // Abort mid-issue
        accept(32'sd32768);
        n = 0;
        while (!(MacEn === 1'b1 && CoeffAddr == 6'd20) && n < 60) begin
            step();
            n++;
        end
        chk("abort_reach_addr", CoeffAddr, 20);
        chk("sat_sticky", SatFlag, exp_sat_flag);
        Rst = 1'b1;
        step();
        chk("abort_mac_en", MacEn, 0);
        chk("abort_out_valid", OutValid, 0);
        chk("abort_in_ready", InReady, 0);
        chk("abort_busy", Busy, 1);
        chk("abort_sat_flag", SatFlag, 0);
        Rst = 1'b0;
        check_clear();
        run_impulse();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
